// File: rtl/fwd_sel_if.sv
// ID-stage hazard bus between the decode stage and the operand-forwarding controller.
// master = decode stage side, slave = forwarding controller.
interface fwd_sel_if #(
   parameter int REG_BITS = 5
);
   logic                id_valid;
   logic [REG_BITS-1:0] id_rn;
   logic [REG_BITS-1:0] id_rm;
   logic                id_use_rn;
   logic                id_use_rm;
   logic [REG_BITS-1:0] id_rd;
   logic                id_regwrite;
   logic                id_memread;
   logic                flush;
   logic                stall;
   logic [1:0]          fwd_a_sel;
   logic [1:0]          fwd_b_sel;

   modport master (
      output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
             id_regwrite, id_memread, flush,
      input  stall, fwd_a_sel, fwd_b_sel
   );

   modport slave (
      input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
             id_regwrite, id_memread, flush,
      output stall, fwd_a_sel, fwd_b_sel
   );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// EX-stage operand-forwarding select generator with load-use stall detection.
// Tracks producer metadata for EX, MEM and WB; selects are registered as the ID instruction enters EX.
module fwd_sel_ctrl #(
   parameter int REG_BITS = 5,
   parameter int ZERO_REG = 31
) (
   input  logic     clk,
   input  logic     reset_n,
   fwd_sel_if.slave bus
);

   localparam logic [REG_BITS-1:0] ZR = REG_BITS'(ZERO_REG);

   typedef struct packed {
      logic                valid;
      logic [REG_BITS-1:0] rd;
      logic                regwrite;
      logic                memread;
   } stage_t;

   stage_t     ex_rec;
   stage_t     mem_rec;
   stage_t     wb_rec;
   logic [1:0] sel_a;
   logic [1:0] sel_b;
   logic       stall_c;
   logic       bubble;
   logic       load_in_ex;
   logic [1:0] sel_a_nxt;
   logic [1:0] sel_b_nxt;

   function automatic logic writes(input stage_t s, input logic [REG_BITS-1:0] r);
      return s.valid & s.regwrite & (s.rd == r) & (r != ZR);
   endfunction

   // Youngest producer wins: EX/MEM result, then MEM/WB, then the late WB bypass.
   function automatic logic [1:0] pick(input logic use_r, input logic [REG_BITS-1:0] r,
                                       input stage_t ex_s, input stage_t mem_s,
                                       input stage_t wb_s);
      logic [1:0] sel;
      sel = 2'b00;
      if (use_r && (r != ZR)) begin
         if (writes(ex_s, r))
            sel = 2'b01;
         else if (writes(mem_s, r))
            sel = 2'b10;
         else if (writes(wb_s, r))
            sel = 2'b11;
      end
      return sel;
   endfunction

   always_comb begin
      load_in_ex = ex_rec.valid & ex_rec.memread & ex_rec.regwrite & (ex_rec.rd != ZR);
      stall_c    = bus.id_valid & ~bus.flush & load_in_ex &
                   ((bus.id_use_rn & (bus.id_rn == ex_rec.rd)) |
                    (bus.id_use_rm & (bus.id_rm == ex_rec.rd)));
      bubble     = bus.flush | stall_c | ~bus.id_valid;
      sel_a_nxt  = bubble ? 2'b00 : pick(bus.id_use_rn, bus.id_rn, ex_rec, mem_rec, wb_rec);
      sel_b_nxt  = bubble ? 2'b00 : pick(bus.id_use_rm, bus.id_rm, ex_rec, mem_rec, wb_rec);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_rec  <= '0;
         mem_rec <= '0;
         wb_rec  <= '0;
         sel_a   <= 2'b00;
         sel_b   <= 2'b00;
      end else begin
         wb_rec  <= mem_rec;
         mem_rec <= ex_rec;
         if (bubble)
            ex_rec <= '0;
         else
            ex_rec <= '{valid: 1'b1, rd: bus.id_rd, regwrite: bus.id_regwrite,
                        memread: bus.id_memread};
         sel_a   <= sel_a_nxt;
         sel_b   <= sel_b_nxt;
      end
   end

   assign bus.stall     = stall_c;
   assign bus.fwd_a_sel = sel_a;
   assign bus.fwd_b_sel = sel_b;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Self-checking bench for fwd_sel_ctrl: directed hazard scenarios plus random instruction streams
// checked against a reference model based on producer distance in the issue history.
module tb_fwd_sel_ctrl;

   logic clk;
   logic reset_n;
   int   total;
   int   bad;

   fwd_sel_if #(.REG_BITS(5)) bus ();

   fwd_sel_ctrl #(.REG_BITS(5), .ZERO_REG(31)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [4:0] rn;
      logic       urn;
      logic [4:0] rm;
      logic       urm;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
      logic       fl;
   } ins_t;

   // Issue history: q[0] is the most recently issued slot (bubbles included), q[k] is k+1 ahead.
   ins_t q[$];

   function automatic ins_t mk(input logic v, input logic [4:0] rn, input logic urn,
                               input logic [4:0] rm, input logic urm, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic fl);
      ins_t i;
      i.v = v; i.rn = rn; i.urn = urn; i.rm = rm; i.urm = urm;
      i.rd = rd; i.rw = rw; i.mr = mr; i.fl = fl;
      return i;
   endfunction

   function automatic ins_t nop();
      return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic logic prod_writes(input ins_t p, input logic [4:0] r);
      return p.v && p.rw && (p.rd == r) && (r != 5'd31);
   endfunction

   // Distance to the nearest producer (1..3) is the select code itself; none in range -> 00.
   function automatic logic [1:0] model_sel(input logic u, input logic [4:0] r);
      if (!u || r == 5'd31) return 2'b00;
      for (int d = 0; d < 3; d++)
         if (prod_writes(q[d], r)) return 2'(d + 1);
      return 2'b00;
   endfunction

   function automatic logic model_stall(input ins_t i);
      ins_t p;
      p = q[0];
      if (!i.v || i.fl) return 1'b0;
      if (!(p.v && p.mr && p.rw && p.rd != 5'd31)) return 1'b0;
      return (i.urn && i.rn == p.rd) || (i.urm && i.rm == p.rd);
   endfunction

   task automatic clear_model();
      q.delete();
      for (int k = 0; k < 3; k++) q.push_back(nop());
   endtask

   task automatic drive(input ins_t i);
      bus.id_valid    = i.v;
      bus.id_rn       = i.rn;
      bus.id_use_rn   = i.urn;
      bus.id_rm       = i.rm;
      bus.id_use_rm   = i.urm;
      bus.id_rd       = i.rd;
      bus.id_regwrite = i.rw;
      bus.id_memread  = i.mr;
      bus.flush       = i.fl;
   endtask

   // Presents one instruction for one cycle; returns model predictions and DUT observations.
   task automatic cycle(input ins_t i, output logic es, output logic os,
                        output logic [1:0] ea, output logic [1:0] eb,
                        output logic [1:0] oa, output logic [1:0] ob);
      logic bub;
      drive(i);
      #3;
      os  = bus.stall;
      es  = model_stall(i);
      bub = i.fl || es || !i.v;
      ea  = bub ? 2'b00 : model_sel(i.urn, i.rn);
      eb  = bub ? 2'b00 : model_sel(i.urm, i.rm);
      @(posedge clk);
      #1;
      oa = bus.fwd_a_sel;
      ob = bus.fwd_b_sel;
      q.push_front(bub ? nop() : i);
      void'(q.pop_back());
   endtask

   task automatic do_reset();
      drive(nop());
      reset_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      clear_model();
   endtask

   // Runs a program; an instruction the model predicts stalled is re-presented the next cycle.
   task automatic run_prog(input string name, input ins_t prog[$], output int stalls);
      logic es, os;
      logic [1:0] ea, eb, oa, ob;
      int tries;
      stalls = 0;
      foreach (prog[n]) begin
         tries = 0;
         do begin
            cycle(prog[n], es, os, ea, eb, oa, ob);
            tries++;
            if (os) stalls++;
            total++;
            if (os !== es) begin
               bad++; $display("FAIL %s stall step %0d: got %b want %b", name, n, os, es);
            end
            total++;
            if (oa !== ea) begin
               bad++; $display("FAIL %s fwd_a step %0d: got %b want %b", name, n, oa, ea);
            end
            total++;
            if (ob !== eb) begin
               bad++; $display("FAIL %s fwd_b step %0d: got %b want %b", name, n, ob, eb);
            end
         end while (es && tries < 3);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      total++;
      if (bus.stall !== 1'b0) begin
         bad++; $display("FAIL reset stall: got %b want 0", bus.stall);
      end
      total++;
      if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00) begin
         bad++; $display("FAIL reset sels: got %b/%b want 00/00", bus.fwd_a_sel, bus.fwd_b_sel);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_ex_fwd();
      ins_t p[$];
      int st;
      logic es, os;
      logic [1:0] ea, eb, oa, ob;
      p.push_back(mk(1, 5'd7, 1, 5'd8, 1, 5'd1, 1, 0, 0));
      run_prog("ex_fwd_prod", p, st);
      cycle(mk(1, 5'd1, 1, 5'd5, 1, 5'd9, 1, 0, 0), es, os, ea, eb, oa, ob);
      total++;
      if (oa !== 2'b01 || ob !== 2'b00 || os !== 1'b0) begin
         bad++; $display("FAIL ex_fwd sub: got a=%b b=%b stall=%b want 01 00 0", oa, ob, os);
      end
   endtask

   task automatic test_distance();
      logic es, os;
      logic [1:0] ea, eb, oa, ob;
      logic [1:0] want;
      for (int gap = 1; gap <= 3; gap++) begin
         do_reset();
         cycle(mk(1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 0), es, os, ea, eb, oa, ob);
         for (int k = 0; k < gap; k++)
            cycle(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0), es, os, ea, eb, oa, ob);
         cycle(mk(1, 5'd6, 1, 5'd2, 1, 5'd10, 1, 0, 0), es, os, ea, eb, oa, ob);
         want = (gap == 1) ? 2'b10 : (gap == 2) ? 2'b11 : 2'b00;
         total++;
         if (ob !== want || ob !== eb) begin
            bad++; $display("FAIL distance gap=%0d: got %b want %b", gap, ob, want);
         end
      end
   endtask

   task automatic test_load_use();
      ins_t p[$];
      int st;
      logic es, os;
      logic [1:0] ea, eb, oa, ob;
      do_reset();
      cycle(mk(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 0), es, os, ea, eb, oa, ob);
      cycle(mk(1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0), es, os, ea, eb, oa, ob);
      total++;
      if (os !== 1'b1 || oa !== 2'b00 || ob !== 2'b00) begin
         bad++; $display("FAIL load_use stall: got stall=%b a=%b b=%b want 1 00 00", os, oa, ob);
      end
      cycle(mk(1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0), es, os, ea, eb, oa, ob);
      total++;
      if (os !== 1'b0 || oa !== 2'b10) begin
         bad++; $display("FAIL load_use held: got stall=%b a=%b want 0 10", os, oa);
      end
      p.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 1, 0));
      p.push_back(mk(1, 5'd1, 0, 5'd12, 1, 5'd13, 1, 0, 0));
      run_prog("load_use_rm", p, st);
      total++;
      if (st != 1) begin
         bad++; $display("FAIL load_use_rm count: got %0d want 1", st);
      end
   endtask

   task automatic test_zero_reg();
      ins_t p[$];
      int st;
      do_reset();
      p.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd31, 1, 0, 0));
      p.push_back(mk(1, 5'd31, 1, 5'd31, 1, 5'd6, 1, 0, 0));
      p.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd31, 1, 1, 0));
      p.push_back(mk(1, 5'd31, 1, 5'd31, 1, 5'd7, 1, 0, 0));
      run_prog("zero_reg", p, st);
      total++;
      if (st != 0) begin
         bad++; $display("FAIL zero_reg stalls: got %0d want 0", st);
      end
   endtask

   task automatic test_back_to_back();
      ins_t p[$];
      int st;
      logic es, os;
      logic [1:0] ea, eb, oa, ob;
      do_reset();
      p.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 0));
      p.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 0));
      run_prog("b2b_prod", p, st);
      cycle(mk(1, 5'd4, 1, 5'd4, 1, 5'd8, 1, 0, 0), es, os, ea, eb, oa, ob);
      total++;
      if (oa !== 2'b01 || ob !== 2'b01) begin
         bad++; $display("FAIL back_to_back: got a=%b b=%b want 01 01", oa, ob);
      end
   endtask

   task automatic test_flush_reset();
      logic es, os;
      logic [1:0] ea, eb, oa, ob;
      do_reset();
      cycle(mk(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 0), es, os, ea, eb, oa, ob);
      cycle(mk(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 1), es, os, ea, eb, oa, ob);
      total++;
      if (os !== 1'b0 || oa !== 2'b00) begin
         bad++; $display("FAIL flush: got stall=%b a=%b want 0 00", os, oa);
      end
      cycle(mk(1, 5'd3, 1, 5'd0, 0, 5'd9, 1, 0, 0), es, os, ea, eb, oa, ob);
      total++;
      if (os !== 1'b0 || oa !== 2'b10) begin
         bad++; $display("FAIL flush next: got stall=%b a=%b want 0 10", os, oa);
      end
      // Reset landing in a stall cycle.
      cycle(mk(1, 5'd0, 0, 5'd0, 0, 5'd14, 1, 1, 0), es, os, ea, eb, oa, ob);
      drive(mk(1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0, 0));
      #3;
      total++;
      if (bus.stall !== 1'b1) begin
         bad++; $display("FAIL pre_reset stall: got %b want 1", bus.stall);
      end
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      clear_model();
      drive(nop());
      #2;
      total++;
      if (bus.stall !== 1'b0 || bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00) begin
         bad++; $display("FAIL mid_stall reset: got stall=%b a=%b b=%b want 0 00 00",
                         bus.stall, bus.fwd_a_sel, bus.fwd_b_sel);
      end
      @(posedge clk);
      #1;
      cycle(mk(1, 5'd14, 1, 5'd14, 1, 5'd15, 1, 0, 0), es, os, ea, eb, oa, ob);
      total++;
      if (os !== 1'b0 || oa !== 2'b00 || ob !== 2'b00) begin
         bad++; $display("FAIL post_reset reader: got stall=%b a=%b b=%b want 0 00 00",
                         os, oa, ob);
      end
   endtask

   task automatic test_random();
      ins_t p[$];
      int st;
      logic [4:0] regs[5];
      regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd4; regs[4] = 5'd31;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         p.push_back(mk($urandom_range(99) < 85,
                        regs[$urandom_range(4)], 1'($urandom),
                        regs[$urandom_range(4)], 1'($urandom),
                        regs[$urandom_range(4)], $urandom_range(99) < 75,
                        $urandom_range(99) < 35, $urandom_range(99) < 10));
      end
      run_prog("random", p, st);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset_n = 1'b0;
      drive(nop());
      clear_model();
      @(posedge clk);
      #1;
      test_reset();
      test_ex_fwd();
      test_distance();
      test_load_use();
      test_zero_reg();
      test_back_to_back();
      test_flush_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
